// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state encoding, opcode map and opcode-class helpers for the multi-cycle sequencer
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MDWAIT = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_BRANCH = 3'd6
    } state_t;

    localparam logic [3:0] OP_MUL   = 4'b0000;
    localparam logic [3:0] OP_MULI  = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVI  = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_LOAD  = 4'b0101;
    localparam logic [3:0] OP_STORE = 4'b0110;
    localparam logic [3:0] OP_B     = 4'b0111;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_ADDI  = 4'b1111;

    // MUL/MULI/DIV/DIVI all go through the iterative unit
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b00;
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return op == OP_LOAD || op == OP_STORE;
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return op == OP_B || op == OP_BEQ;
    endfunction

    // 1001..1110 have no instruction assigned
    function automatic logic is_illegal(input logic [3:0] op);
        return op >= 4'b1001 && op <= 4'b1110;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: clearable up-counter flagging the terminal count LIMIT-1 while enabled
module cycle_timer #(
    parameter int LIMIT = 64,
    parameter int W     = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [W-1:0] count;

    // count cycles spent enabled; clear takes priority over counting
    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    assign tc = enable && count == W'(LIMIT - 1);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/writeback sequencer with mult/div and memory stalls
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       instr_valid,
    input  logic       mem_ready,
    input  logic       alu_done,
    input  logic       flag_z,
    output logic       pc_write,
    output logic       pc_src,
    output logic       ir_write,
    output logic       alu_start,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       flag_write,
    output logic       err,
    output logic [2:0] state_o
);

    state_t     state, state_nx;
    logic [3:0] op_q;
    logic       md_timeout;

    cycle_timer #(.LIMIT(TIMEOUT_CYCLES), .W(CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == ST_DECODE),
        .enable (state == ST_MDWAIT),
        .tc     (md_timeout)
    );

    // state register and opcode capture during DECODE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            op_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_DECODE)
                op_q <= opcode;
        end
    end

    // next state and strobes; everything held low while reset is asserted
    always_comb begin
        state_nx   = state;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        alu_start  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        flag_write = 1'b0;
        err        = 1'b0;
        if (rst_n) begin
            case (state)
                ST_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = instr_valid;
                    state_nx = instr_valid ? ST_DECODE : ST_FETCH;
                end
                ST_DECODE: begin
                    if (is_muldiv(opcode)) begin
                        alu_start = 1'b1;
                        state_nx  = ST_MDWAIT;
                    end else if (is_illegal(opcode)) begin
                        err      = 1'b1;
                        pc_write = 1'b1;
                        state_nx = ST_FETCH;
                    end else begin
                        state_nx = is_branch(opcode) ? ST_BRANCH : ST_EXEC;
                    end
                end
                ST_MDWAIT: begin
                    if (alu_done) begin
                        state_nx = ST_WB;
                    end else if (md_timeout) begin
                        err      = 1'b1;
                        pc_write = 1'b1;
                        state_nx = ST_FETCH;
                    end
                end
                ST_EXEC: state_nx = is_mem(op_q) ? ST_MEM : ST_WB;
                ST_MEM: begin
                    mem_write = op_q == OP_STORE;
                    mem_read  = op_q != OP_STORE;
                    pc_write  = op_q == OP_STORE && mem_ready;
                    state_nx  = !mem_ready ? ST_MEM : (op_q == OP_STORE ? ST_FETCH : ST_WB);
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    flag_write = 1'b1;
                    state_nx   = ST_FETCH;
                end
                ST_BRANCH: begin
                    pc_write = 1'b1;
                    pc_src   = op_q == OP_B || flag_z;
                    state_nx = ST_FETCH;
                end
                default: state_nx = ST_FETCH;
            endcase
        end
    end

    assign state_o = rst_n ? state : 3'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-scenario checks of the multi-cycle sequencer
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       instr_valid = 1'b0, mem_ready = 1'b0, alu_done = 1'b0, flag_z = 1'b0;
    logic       pc_write, pc_src, ir_write, alu_start, mem_read, mem_write;
    logic       reg_write, flag_write, err;
    logic [2:0] state_o;
    logic [11:0] obs;
    int checks = 0;
    int fails  = 0;

    multicycle_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .alu_done(alu_done), .flag_z(flag_z),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .alu_start(alu_start),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .flag_write(flag_write), .err(err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // {state, pc_write, pc_src, ir_write, alu_start, mem_read, mem_write, reg_write, flag_write, err}
    assign obs = {state_o, pc_write, pc_src, ir_write, alu_start, mem_read, mem_write,
                  reg_write, flag_write, err};

    task automatic test_reset();
        rst_n = 1'b0; instr_valid = 1'b1; opcode = OP_ADD;
        @(negedge clk); @(negedge clk);
        #1 checks++;
        if (obs !== 12'd0) begin fails++; $display("FAIL reset_outputs: got %b expected %b", obs, 12'd0); end
        @(negedge clk);
        instr_valid = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 checks++;
            if (obs !== {3'd0, 9'b000010000}) begin fails++; $display("FAIL reset_fetch_hold %0d: got %b expected %b", i, obs, {3'd0, 9'b000010000}); end
            @(negedge clk);
        end
    endtask

    task automatic test_add();
        logic [11:0] ex [4];
        ex = '{{3'd0, 9'b001010000}, {3'd1, 9'b0}, {3'd2, 9'b0}, {3'd5, 9'b100000110}};
        opcode = OP_ADD; instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 checks++;
            if (obs !== ex[i]) begin fails++; $display("FAIL add cycle %0d: got %b expected %b", i, obs, ex[i]); end
            @(negedge clk);
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_load();
        logic [11:0] ex [7];
        logic        mr [7];
        ex = '{{3'd0, 9'b001010000}, {3'd1, 9'b0}, {3'd2, 9'b0}, {3'd4, 9'b000010000},
               {3'd4, 9'b000010000}, {3'd4, 9'b000010000}, {3'd5, 9'b100000110}};
        mr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        opcode = OP_LOAD; instr_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i];
            #1 checks++;
            if (obs !== ex[i]) begin fails++; $display("FAIL load cycle %0d: got %b expected %b", i, obs, ex[i]); end
            @(negedge clk);
        end
        instr_valid = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_store();
        logic [11:0] ex [6];
        logic        mr [6];
        ex = '{{3'd0, 9'b001010000}, {3'd1, 9'b0}, {3'd2, 9'b0}, {3'd4, 9'b000001000},
               {3'd4, 9'b100001000}, {3'd0, 9'b000010000}};
        mr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        opcode = OP_STORE; instr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_ready = mr[i];
            if (i == 5) instr_valid = 1'b0;
            #1 checks++;
            if (obs !== ex[i]) begin fails++; $display("FAIL store cycle %0d: got %b expected %b", i, obs, ex[i]); end
            @(negedge clk);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_branch(input logic [3:0] op, input logic z, input logic src);
        logic [11:0] ex [3];
        ex = '{{3'd0, 9'b001010000}, {3'd1, 9'b0}, {3'd6, 1'b1, src, 7'b0}};
        opcode = op; flag_z = z; instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 checks++;
            if (obs !== ex[i]) begin fails++; $display("FAIL branch op=%b z=%b cycle %0d: got %b expected %b", op, z, i, obs, ex[i]); end
            @(negedge clk);
        end
        instr_valid = 1'b0; flag_z = 1'b0;
    endtask

    task automatic test_illegal();
        logic [11:0] ex [3];
        ex = '{{3'd0, 9'b001010000}, {3'd1, 9'b100000001}, {3'd0, 9'b000010000}};
        opcode = 4'b1010; instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) instr_valid = 1'b0;
            #1 checks++;
            if (obs !== ex[i]) begin fails++; $display("FAIL illegal cycle %0d: got %b expected %b", i, obs, ex[i]); end
            @(negedge clk);
        end
    endtask

    // alu_done arrives on the n-th MDWAIT cycle; n=64 coincides with the timeout
    task automatic test_muldiv(input int n);
        opcode = OP_MUL; instr_valid = 1'b1;
        #1 checks++;
        if (obs !== {3'd0, 9'b001010000}) begin fails++; $display("FAIL mul%0d fetch: got %b", n, obs); end
        @(negedge clk);
        instr_valid = 1'b0;
        #1 checks++;
        if (obs !== {3'd1, 9'b000100000}) begin fails++; $display("FAIL mul%0d decode: got %b expected %b", n, obs, {3'd1, 9'b000100000}); end
        @(negedge clk);
        for (int i = 1; i <= n; i++) begin
            alu_done = (i == n);
            #1 checks++;
            if (obs !== {3'd3, 9'b0}) begin fails++; $display("FAIL mul%0d wait %0d: got %b expected %b", n, i, obs, {3'd3, 9'b0}); end
            @(negedge clk);
        end
        alu_done = 1'b0;
        #1 checks++;
        if (obs !== {3'd5, 9'b100000110}) begin fails++; $display("FAIL mul%0d wb: got %b expected %b", n, obs, {3'd5, 9'b100000110}); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        opcode = OP_MUL; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 64; i++) begin
            #1 checks++;
            if (i < 64 && obs !== {3'd3, 9'b0}) begin fails++; $display("FAIL timeout wait %0d: got %b expected %b", i, obs, {3'd3, 9'b0}); end
            if (i == 64 && obs !== {3'd3, 9'b100000001}) begin fails++; $display("FAIL timeout err: got %b expected %b", obs, {3'd3, 9'b100000001}); end
            @(negedge clk);
        end
        #1 checks++;
        if (obs !== {3'd0, 9'b000010000}) begin fails++; $display("FAIL timeout return: got %b expected %b", obs, {3'd0, 9'b000010000}); end
        @(negedge clk);
    endtask

    task automatic test_reset_mdwait();
        opcode = OP_DIV; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1 checks++;
        if (obs !== 12'd0) begin fails++; $display("FAIL rst_mdwait during: got %b expected %b", obs, 12'd0); end
        @(negedge clk);
        rst_n = 1'b1;
        #1 checks++;
        if (obs !== {3'd0, 9'b000010000}) begin fails++; $display("FAIL rst_mdwait after: got %b expected %b", obs, {3'd0, 9'b000010000}); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_load();
        test_store();
        test_branch(OP_BEQ, 1'b1, 1'b1);
        test_branch(OP_BEQ, 1'b0, 1'b0);
        test_branch(OP_B, 1'b0, 1'b1);
        test_illegal();
        test_muldiv(10);
        test_muldiv(64);
        test_timeout();
        test_reset_mdwait();
        test_add();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
